// File: rtl/tick_generator.sv
// Multi-channel programmable clock-enable generator: each channel is either an
// integer reload divider or a fractional phase accumulator, reconfigured at runtime.
module tick_generator #(
    parameter int CLK_FREQ  = 25000000,
    parameter int NUM_CH    = 4,
    parameter int ACC_WIDTH = 32,
    parameter int RTC_DIV   = (CLK_FREQ / 32768) / 2 - 1,
    parameter int BAUD_DIV  = CLK_FREQ / 115200 - 1
) (
    input  logic                   reset,
    input  logic                   clock,
    input  logic                   cfg_valid,
    input  logic [3:0]             cfg_ch,
    input  logic                   cfg_en,
    input  logic                   cfg_frac,
    input  logic [ACC_WIDTH-1:0]   cfg_value,
    output logic                   cfg_error,
    input  logic [3:0]             rd_ch,
    output logic [ACC_WIDTH+1:0]   rd_data,
    output logic [NUM_CH-1:0]      tick,
    output logic [NUM_CH-1:0]      tick_toggle
);

    // Config port: cfg_valid is a one-cycle write strobe sampled at every rising
    // edge; there is no ready, so every strobe is consumed in the cycle it is seen.
    logic [ACC_WIDTH+1:0] reg_view [16];

    for (genvar i = 0; i < 16; i++) begin : g_slot
        if (i < NUM_CH) begin : g_ch
            localparam logic                 RST_EN  = (i < 2);
            localparam logic [ACC_WIDTH-1:0] RST_VAL = (i == 0) ? ACC_WIDTH'(RTC_DIV) :
                                                       (i == 1) ? ACC_WIDTH'(BAUD_DIV) : '0;

            logic                 en_q;
            logic                 frac_q;
            logic [ACC_WIDTH-1:0] value_q;
            logic [ACC_WIDTH-1:0] cnt_q;
            logic                 tick_q;
            logic                 toggle_q;
            logic                 wr_hit;
            logic [ACC_WIDTH:0]   sum;

            assign wr_hit = cfg_valid && (cfg_ch == 4'(i));
            assign sum    = {1'b0, cnt_q} + {1'b0, value_q};

            // cnt_q is the down-counter in integer mode and the phase accumulator
            // in fractional mode; a write always restarts it and suppresses the tick.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    en_q     <= RST_EN;
                    frac_q   <= 1'b0;
                    value_q  <= RST_VAL;
                    cnt_q    <= RST_VAL;
                    tick_q   <= 1'b0;
                    toggle_q <= 1'b0;
                end else if (wr_hit) begin
                    en_q    <= cfg_en;
                    frac_q  <= cfg_frac;
                    value_q <= cfg_value;
                    cnt_q   <= cfg_frac ? '0 : cfg_value;
                    tick_q  <= 1'b0;
                end else if (en_q) begin
                    if (frac_q) begin
                        cnt_q  <= sum[ACC_WIDTH-1:0];
                        tick_q <= sum[ACC_WIDTH];
                        if (sum[ACC_WIDTH]) begin
                            toggle_q <= ~toggle_q;
                        end
                    end else if (cnt_q == '0) begin
                        cnt_q    <= value_q;
                        tick_q   <= 1'b1;
                        toggle_q <= ~toggle_q;
                    end else begin
                        cnt_q  <= cnt_q - ACC_WIDTH'(1);
                        tick_q <= 1'b0;
                    end
                end else begin
                    tick_q <= 1'b0;
                end
            end

            assign tick[i]        = tick_q;
            assign tick_toggle[i] = toggle_q;
            assign reg_view[i]    = {en_q, frac_q, value_q};
        end else begin : g_unused
            assign reg_view[i] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cfg_error <= 1'b0;
            rd_data   <= '0;
        end else begin
            cfg_error <= cfg_valid && (int'(cfg_ch) >= NUM_CH);
            rd_data   <= reg_view[rd_ch];
        end
    end

endmodule
